out_fifo4: RTL and testbench
============================

# out_fifo4

Elastic buffer directly downstream of the byte-select stage: captures its 8-bit result under a valid/ready handshake. Holds up to DEPTH bytes in first-word-fall-through order and presents them to the next consumer. It decouples the combinational select datapath from a consumer that may stall. It also flags any byte the producer offered while the buffer was full.

## Interface
- DEPTH, 4, number of byte entries; must be a power of two, minimum 2
- CW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all state
- flush  input  1  synchronous clear of stored data (pointers and count only)
- in_valid  input  1  producer offers in_data this cycle
- in_data  input  8  byte from the upstream select stage
- in_ready  output  1  buffer can accept a byte this cycle
- out_valid  output  1  out_data holds the oldest stored byte
- out_data  output  8  oldest stored byte (FWFT)
- out_ready  input  1  consumer takes out_data this cycle
- count  output  CW  number of stored bytes, 0..DEPTH
- drop_err  output  1  sticky: a byte was offered while in_ready was low

## Operation
- Storage: DEPTH x 8 register array; write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Push: occurs when in_valid && in_ready. mem[wp] <= in_data; wp <= wp+1.
- Pop: occurs when out_valid && out_ready. rp <= rp+1.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- in_ready = (count != DEPTH). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_data = mem[rp]. When count == 0, out_data is don't-care; the bench must not check it.
- Full + pop: in_ready is low, so no push that cycle. The entry freed by the pop is accepted from the next cycle.
- Empty + in_valid: the push lands and out_valid rises the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop at 0 < count < DEPTH: both take effect; count is unchanged; pointers advance independently.
- drop_err: set on the edge after any cycle with in_valid && !in_ready. It stays set until reset and is unaffected by flush.
- flush: wp, rp and count are cleared to 0. Any push or pop in the same cycle is ignored. Memory contents are not cleared.
- reset takes priority over flush and over any handshake.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1, drop_err=0, wp=rp=0. out_data is undefined and the memory is not reset.
- Latency: a byte pushed in cycle N is visible on out_data with out_valid=1 in cycle N+1, if it is at the head.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- All outputs except out_data are driven directly from registers. out_data is a mux of registers selected by rp.
- Reset asserted mid-stream: on the next edge all state is at reset values and stored bytes are discarded. The first push after reset deasserts goes to entry 0.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble. Ordering is preserved across the wrap.

## Test plan
- Reset then idle: hold reset 2 cycles, then check count=0, out_valid=0, in_ready=1, drop_err=0. Push 0xA5 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1.
- Fill and overflow: push 0x01..0x04 back-to-back with out_ready=0 -> count=4, in_ready=0. Offer 0x05 -> drop_err=1 next cycle, count stays 4. Drain -> 0x01,0x02,0x03,0x04 in order, 0x05 never appears, drop_err stays 1.
- Streaming and wrap: out_ready=1, push 0x10..0x1B on consecutive cycles -> each byte appears one cycle after its push, in order. count never exceeds 1 and there is no gap across pointer wrap.
- Simultaneous push/pop at count=2 (held 0x20,0x21): push 0x22 while popping -> count stays 2, head becomes 0x21, next outputs 0x21 then 0x22.
- Flush vs drop_err: with drop_err=1 and count=3, pulse flush while in_valid=1 (0x77) and out_ready=1 -> next cycle count=0, out_valid=0, drop_err=1. 0x77 was not stored; a following push of 0x30 is output first.
- Reset mid-operation: count=3, assert reset for one cycle with in_valid=1 -> all outputs at reset values. Subsequent push of 0x55 -> out_data=0x55 with count=1.

Source files
------------

// File: rtl/out_fifo4.sv
`default_nettype none
// ============================================================================
// Module      : out_fifo4
// Description : FWFT byte FIFO behind the byte-select stage, with a sticky
//               overflow flag for bytes offered while full.
// Revision    : 1.0 - initial release
// ============================================================================
module out_fifo4 #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_drop_err;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    always_comb begin
        w_push      = in_valid && r_in_ready;
        w_pop       = r_out_valid && out_ready;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Flags are registered from the next count so every status output comes
    // straight off a flop, with no path from out_ready to in_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != C_FULL);
            r_out_valid <= (w_count_nxt != '0);
        end
    end

    // Overflow flag survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_err <= 1'b0;
        end else if (in_valid && !r_in_ready) begin
            r_drop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_mem[r_rp];
    assign count     = r_count;
    assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_out_fifo4.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_fifo4
// Description : Scoreboard bench for out_fifo4 (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_fifo4;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          drop_err;

    out_fifo4 #(.DEPTH(DEPTH), .CW(CW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sb_q [$];
    bit         exp_drop;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check DUT state against the model at the
    // falling edge, then advance the model to what the next edge produces.
    task automatic step(input logic v, input logic [7:0] d, input logic ordy,
                        input logic fl, input logic rs);
        int         cnt_before;
        logic [7:0] exp_byte;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        cnt_before = sb_q.size();
        @(negedge clk);
        chk("count", 32'(count), 32'(cnt_before));
        chk("out_valid", 32'(out_valid), 32'(cnt_before != 0));
        chk("in_ready", 32'(in_ready), 32'(cnt_before != DEPTH));
        chk("drop_err", 32'(drop_err), 32'(exp_drop));
        if (cnt_before != 0 && ordy && !fl && !rs) begin
            exp_byte = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(exp_byte));
        end
        if (!fl && !rs && v && cnt_before < DEPTH) begin
            sb_q.push_back(d);
        end
        if (rs) begin
            exp_drop = 1'b0;
        end else if (v && cnt_before == DEPTH) begin
            exp_drop = 1'b1;
        end
        if (rs || fl) begin
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_drop  = 1'b0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then single byte
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("first_head", 32'(out_data), 32'h A5);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("drop_set", 32'(drop_err), 32'h1);
        chk("full_count", 32'(count), 32'h4);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Streaming across pointer wrap
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Simultaneous push and pop at count 2
        step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        chk("simul_head", 32'(out_data), 32'h21);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with drop_err set and count 3
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        chk("flush_drop", 32'(drop_err), 32'h1);
        chk("flush_count", 32'(count), 32'h0);
        step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("rst_drop", 32'(drop_err), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: %0d bytes left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
